bcd_timer_scan: RTL and testbench
=================================

// Module: bcd_timer_scan
// PURPOSE
//  Parametrised BCD seconds timer with integrated 4-digit 7-segment scan driver.
//  Generalises the fixed 60 s counter: configurable digit count, terminal value,
//  up/down mode, synchronous preset load, and a terminal pulse.
//  Sits directly under a board top: clk in, segment/digit pins out.
// PARAMETERS
//  CLK_HZ   50_000_000  input clock frequency
//  TICK_HZ  1           count rate
//  SCAN_HZ  190         full 4-digit refresh rate
//  NDIG     2           active BCD digits, 1..4; digit 0 is rightmost
//  MAX_BCD  16'h0059    terminal value in BCD; nibbles >= NDIG must be 0
// PORTS
//  clk       in   1   system clock
//  clr       in   1   asynchronous active-high reset
//  stay      in   1   1 = hold count and freeze prescaler
//  dir       in   1   0 = count up, 1 = count down
//  load      in   1   synchronous preset strobe
//  load_val  in   16  BCD preset value
//  done      out  1   one-cycle pulse on wrap
//  qc        out  8   segments {a,b,c,d,e,f,g,dp}, active-low
//  wei       out  4   digit enables, active-low; wei[0] = digit 0
// BEHAVIOUR
//  Reset (clr=1, async): count=0, prescaler=0, scan idx=0, done=0,
//   qc=8'hFF, wei=4'b1111.
//  Prescaler: 0..CLK_HZ/TICK_HZ-1. Internal tick asserted for 1 cycle at terminal.
//   Holds its value while stay=1, so resume keeps the fractional second.
//  Count priority per cycle: load > (tick & !stay) > hold.
//   load: count <= load_val, next cycle. If any nibble >9, any nibble >= NDIG
//    is nonzero, or the value exceeds MAX_BCD, count <= MAX_BCD (clamp).
//    load does not reset the prescaler. load during stay is accepted.
//   up: count==MAX_BCD -> 0 and done=1; otherwise BCD +1 with ripple carry.
//   down: count==0 -> MAX_BCD and done=1; otherwise BCD -1 with ripple borrow.
//   dir is sampled at the tick cycle. A change takes effect on the next tick.
//   done is registered and aligned with the count update. It never fires on load.
//  Scan: divider 0..CLK_HZ/(SCAN_HZ*4)-1, advancing idx 0->1->2->3->0.
//   Digit idx < NDIG: wei = ~(1<<idx), qc = decode of nibble idx.
//   Digit idx >= NDIG: wei bit stays 1 (blank).
//   qc/wei are registered: 1-cycle latency from idx or count change; no ghosting.
//   dp is always off (qc[0]=1).
//  Decoder: 0-9 standard patterns, active-low. Illegal nibbles are unreachable.
//  Widths: count is NDIG*4 bits. Prescaler and scan counters use $clog2 of their
//   moduli.
// CONFIGURATION
//  LZ_BLANK_EN defined: leading-zero suppression. A digit above digit 0 is
//   blanked (wei bit 1, qc=8'hFF) when it and every higher active digit are 0.
//   Digit 0 is always shown.
//  LZ_BLANK_EN undefined: all NDIG digits are always shown, including zeros.
// TESTING (sim params CLK_HZ=40, TICK_HZ=1, SCAN_HZ=2 -> tick/40 clk, scan
//  step/5 clk)
//  1 Reset then count up: 59 ticks -> count 16'h0059; tick 60 -> 0, done high
//    for exactly 1 clk.
//  2 dir=1 from 0: 1 tick -> 16'h0059 with done pulse; next tick -> 16'h0058.
//  3 stay=1 at prescaler=20 for 100 clk, then stay=0: next tick 20 clk later;
//    count unchanged during stay.
//  4 load=1, load_val=16'h0042, coincident with tick -> count 16'h0042, no done.
//    load_val=16'h0075 -> 16'h0059 (clamp).
//  5 Scan check with count 16'h0037: wei 1110/qc=7-seg "7", then 1101/"3",
//    then 1111, 1111; each held 5 clk.
//  6 Assert clr mid-tick and mid-scan: outputs reach reset values the same
//    cycle (async). With LZ_BLANK_EN and count 16'h0005: digit 1 blank,
//    digit 0 shows "5".

Source files
------------

// File: rtl/bcd_timer_scan.sv
// Parametrised BCD seconds timer driving a multiplexed 4-digit 7-segment display.
// Optional leading-zero suppression is enabled by defining LZ_BLANK_EN.
module bcd_timer_scan #(
  parameter int          CLK_HZ  = 50_000_000,
  parameter int          TICK_HZ = 1,
  parameter int          SCAN_HZ = 190,
  parameter int          NDIG    = 2,
  parameter logic [15:0] MAX_BCD = 16'h0059
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        stay,
  input  logic        dir,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic        done,
  output logic [7:0]  qc,
  output logic [3:0]  wei
);

  localparam int PRE_MOD  = CLK_HZ / TICK_HZ;
  localparam int SCAN_MOD = CLK_HZ / (SCAN_HZ * 4);
  localparam int PRE_W    = (PRE_MOD > 1) ? $clog2(PRE_MOD) : 1;
  localparam int SCAN_W   = (SCAN_MOD > 1) ? $clog2(SCAN_MOD) : 1;
  localparam int CW       = NDIG * 4;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRE_MOD - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_MOD - 1);
  localparam logic [CW-1:0]     MAX_CNT   = MAX_BCD[CW-1:0];

  logic [PRE_W-1:0]  pre;
  logic [SCAN_W-1:0] sdiv;
  logic [1:0]        idx;
  logic [CW-1:0]     count;
  logic [CW-1:0]     load_cnt;
  logic [15:0]       count_pad;
  logic              tick;
  logic              load_ok;
  logic              lead_zero;
  logic              blank;
  logic [3:0]        nib;
  logic [7:0]        qc_d;
  logic [3:0]        wei_d;

  function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (c) begin
        if (v[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
        else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (b) begin
        if (v[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'd9;
        else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Active-low {a,b,c,d,e,f,g,dp}; dp is never lit.
  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 8'h03;
      4'd1:    return 8'h9F;
      4'd2:    return 8'h25;
      4'd3:    return 8'h0D;
      4'd4:    return 8'h99;
      4'd5:    return 8'h49;
      4'd6:    return 8'h41;
      4'd7:    return 8'h1F;
      4'd8:    return 8'h01;
      4'd9:    return 8'h09;
      default: return 8'hFF;
    endcase
  endfunction

  assign tick      = (pre == PRE_LAST) && !stay;
  assign count_pad = 16'(count);

  // Out-of-range presets (non-BCD, too many digits, above terminal) clamp to MAX_BCD.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    load_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (load_val[i*4 +: 4] > 4'd9) load_ok = 1'b0;
      if (i >= NDIG && load_val[i*4 +: 4] != 4'd0) load_ok = 1'b0;
    end
    if (load_val > MAX_BCD) load_ok = 1'b0;
    load_cnt = load_ok ? load_val[CW-1:0] : MAX_CNT;
  end

  always_ff @(posedge clk or posedge clr) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (clr) begin
      pre   <= '0;
      count <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!stay) pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
      if (load) begin
        count <= load_cnt;
      end else if (tick) begin
        if (!dir) begin
          if (count == MAX_CNT) begin
            count <= '0;
            done  <= 1'b1;
          end else begin
            count <= bcd_inc(count);
          end
        end else begin
          if (count == '0) begin
            count <= MAX_CNT;
            done  <= 1'b1;
          end else begin
            count <= bcd_dec(count);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sdiv <= '0;
      idx  <= 2'd0;
    end else if (sdiv == SCAN_LAST) begin
      sdiv <= '0;
      idx  <= idx + 2'd1;
    end else begin
      sdiv <= sdiv + 1'b1;
    end
  end

  always_comb begin
    nib = count_pad[{idx, 2'b00} +: 4];
`ifdef LZ_BLANK_EN
    lead_zero = (idx != 2'd0);
    for (int i = 1; i < 4; i++) begin
      if (i >= int'(idx) && i < NDIG && count_pad[i*4 +: 4] != 4'd0) lead_zero = 1'b0;
    end
`else
    lead_zero = 1'b0;
`endif
    blank = (int'(idx) >= NDIG) || lead_zero;
    wei_d = blank ? 4'b1111 : ~(4'b0001 << idx);
    qc_d  = blank ? 8'hFF : seg7(nib);
  end

  // Registering the pins keeps digit enable and segments switching on the same edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      qc  <= 8'hFF;
      wei <= 4'b1111;
    end else begin
      qc  <= qc_d;
      wei <= wei_d;
    end
  end

endmodule

// File: tb/tb_bcd_timer_scan.sv
// Self-checking bench for bcd_timer_scan; decimal-valued reference model, honours LZ_BLANK_EN.
module tb_bcd_timer_scan;

  localparam int          CLK_HZ    = 40;
  localparam int          TICK_HZ   = 1;
  localparam int          SCAN_HZ   = 2;
  localparam int          NDIG      = 2;
  localparam logic [15:0] MAX_BCD   = 16'h0059;
  localparam int          TICK_CYC  = 40;
  localparam int          SCAN_STEP = 5;
  localparam int          MAX_DEC   = 59;

  logic        clk = 1'b0;
  logic        clr;
  logic        stay;
  logic        dir;
  logic        load;
  logic [15:0] load_val;
  logic        done;
  logic [7:0]  qc;
  logic [3:0]  wei;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: value kept as a plain decimal integer, time as cycle counts.
  int         m_val;
  int         m_phase;
  int         m_scan;
  logic       m_done;
  logic [7:0] m_qc;
  logic [3:0] m_wei;

  always #5 clk = ~clk;

  bcd_timer_scan #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ),
    .SCAN_HZ(SCAN_HZ),
    .NDIG   (NDIG),
    .MAX_BCD(MAX_BCD)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .stay    (stay),
    .dir     (dir),
    .load    (load),
    .load_val(load_val),
    .done    (done),
    .qc      (qc),
    .wei     (wei)
  );

  // Segments lit for each digit, listed as {a,b,c,d,e,f,g} active-high.
  function automatic logic [7:0] seg_of(input int d);
    logic [6:0] lit;
    case (d)
      0: lit = 7'b1111110;
      1: lit = 7'b0110000;
      2: lit = 7'b1101101;
      3: lit = 7'b1111001;
      4: lit = 7'b0110011;
      5: lit = 7'b1011011;
      6: lit = 7'b1011111;
      7: lit = 7'b1110000;
      8: lit = 7'b1111111;
      default: lit = 7'b1111011;
    endcase
    return {~lit, 1'b1};
  endfunction

  function automatic int clamp_load(input logic [15:0] v);
    int d[4];
    for (int i = 0; i < 4; i++) d[i] = int'(v[i*4 +: 4]);
    if (d[0] > 9 || d[1] > 9 || d[2] > 9 || d[3] > 9) return MAX_DEC;
    if (d[2] != 0 || d[3] != 0) return MAX_DEC;
    if (d[1] * 10 + d[0] > MAX_DEC) return MAX_DEC;
    return d[1] * 10 + d[0];
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic disp_expect(input int pos, input int val, output logic [7:0] q, output logic [3:0] w);
    q = 8'hFF;
    w = 4'b1111;
    if (pos == 0) begin
      q = seg_of(val % 10);
      w = 4'b1110;
    end else if (pos == 1) begin
`ifdef LZ_BLANK_EN
      if (val / 10 != 0) begin
        q = seg_of(val / 10);
        w = 4'b1101;
      end
`else
      q = seg_of(val / 10);
      w = 4'b1101;
`endif
    end
  endtask

  task automatic model_reset();
    m_val   = 0;
    m_phase = 0;
    m_scan  = 0;
    m_done  = 1'b0;
    m_qc    = 8'hFF;
    m_wei   = 4'b1111;
  endtask

  // Advance one clock with the inputs currently driven; model predicts post-edge outputs.
  task automatic step();
    logic tick;
    logic [7:0] eq;
    logic [3:0] ew;
    disp_expect(m_scan / SCAN_STEP, m_val, eq, ew);
    tick = (m_phase == TICK_CYC - 1) && !stay;
    if (!stay) m_phase = (m_phase + 1) % TICK_CYC;
    m_done = 1'b0;
    if (load) m_val = clamp_load(load_val);
    else if (tick) begin
      if (!dir) begin
        if (m_val == MAX_DEC) begin m_val = 0; m_done = 1'b1; end
        else m_val = m_val + 1;
      end else begin
        if (m_val == 0) begin m_val = MAX_DEC; m_done = 1'b1; end
        else m_val = m_val - 1;
      end
    end
    m_scan = (m_scan + 1) % (4 * SCAN_STEP);
    m_qc   = eq;
    m_wei  = ew;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1; stay = 1'b0; dir = 1'b0; load = 1'b0; load_val = 16'h0000;
    @(posedge clk);
    #1;
    clr = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (qc !== 8'hFF) begin n_fail++; $display("FAIL reset_qc: got %h expected ff", qc); end
    n_tests++; if (wei !== 4'b1111) begin n_fail++; $display("FAIL reset_wei: got %b expected 1111", wei); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_tests++; if (dut.count !== 8'h00) begin n_fail++; $display("FAIL reset_count: got %h expected 00", dut.count); end
  endtask

  task automatic test_count_up();
    int pulses;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 59 * TICK_CYC; i++) begin
      step();
      if (done === 1'b1) pulses++;
      n_tests++; if (dut.count !== to_bcd(m_val)) begin n_fail++; $display("FAIL up_count: got %h expected %h", dut.count, to_bcd(m_val)); end
    end
    n_tests++; if (dut.count !== 8'h59) begin n_fail++; $display("FAIL up_at_59: got %h expected 59", dut.count); end
    n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL up_early_done: got %0d pulses expected 0", pulses); end
    repeat (TICK_CYC) begin
      step();
      n_tests++; if (done !== m_done) begin n_fail++; $display("FAIL up_done: got %b expected %b", done, m_done); end
    end
    n_tests++; if (dut.count !== 8'h00 || done !== 1'b1) begin n_fail++; $display("FAIL up_wrap: got %h/%b expected 00/1", dut.count, done); end
    step();
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL up_done_width: got %b expected 0", done); end
  endtask

  task automatic test_count_down();
    do_reset();
    dir = 1'b1;
    repeat (TICK_CYC) step();
    n_tests++; if (dut.count !== 8'h59 || done !== 1'b1) begin n_fail++; $display("FAIL down_wrap: got %h/%b expected 59/1", dut.count, done); end
    step();
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL down_done_width: got %b expected 0", done); end
    repeat (TICK_CYC - 1) step();
    n_tests++; if (dut.count !== 8'h58 || done !== 1'b0) begin n_fail++; $display("FAIL down_58: got %h/%b expected 58/0", dut.count, done); end
  endtask

  task automatic test_stay();
    do_reset();
    repeat (20) step();
    stay = 1'b1;
    repeat (100) begin
      step();
      n_tests++; if (dut.count !== 8'h00) begin n_fail++; $display("FAIL stay_hold: got %h expected 00", dut.count); end
    end
    stay = 1'b0;
    repeat (19) step();
    n_tests++; if (dut.count !== 8'h00) begin n_fail++; $display("FAIL stay_early: got %h expected 00", dut.count); end
    step();
    n_tests++; if (dut.count !== 8'h01) begin n_fail++; $display("FAIL stay_resume: got %h expected 01", dut.count); end
  endtask

  task automatic test_load();
    logic [15:0] vals [7] = '{16'h0075, 16'h00A3, 16'h0105, 16'h0037, 16'h0059, 16'h0000, 16'h005A};
    logic [7:0]  exps [7] = '{8'h59, 8'h59, 8'h59, 8'h37, 8'h59, 8'h00, 8'h59};
    int guard;
    do_reset();
    repeat (TICK_CYC - 1) step();
    load = 1'b1; load_val = 16'h0042;
    step();
    load = 1'b0;
    n_tests++; if (dut.count !== 8'h42 || done !== 1'b0) begin n_fail++; $display("FAIL load_on_tick: got %h/%b expected 42/0", dut.count, done); end
    for (int i = 0; i < 7; i++) begin
      load = 1'b1; load_val = vals[i];
      step();
      load = 1'b0;
      n_tests++; if (dut.count !== exps[i]) begin n_fail++; $display("FAIL load_%h: got %h expected %h", vals[i], dut.count, exps[i]); end
    end
    stay = 1'b1; load = 1'b1; load_val = 16'h0012;
    step();
    stay = 1'b0; load = 1'b0;
    n_tests++; if (dut.count !== 8'h12) begin n_fail++; $display("FAIL load_in_stay: got %h expected 12", dut.count); end
    load = 1'b1; load_val = 16'h0059;
    step();
    load = 1'b0;
    guard = 0;
    while (m_phase != TICK_CYC - 1 && guard < 2 * TICK_CYC) begin step(); guard++; end
    load = 1'b1; load_val = 16'h0010;
    step();
    load = 1'b0;
    n_tests++; if (dut.count !== 8'h10 || done !== 1'b0) begin n_fail++; $display("FAIL load_on_wrap: got %h/%b expected 10/0", dut.count, done); end
  endtask

  task automatic test_scan();
    logic [3:0] ew;
    logic [7:0] eq;
    do_reset();
    load = 1'b1; load_val = 16'h0037;
    step();
    load = 1'b0;
    repeat (19) step();
    for (int k = 0; k < 20; k++) begin
      step();
      ew = (k < 5) ? 4'b1110 : (k < 10) ? 4'b1101 : 4'b1111;
      eq = (k < 5) ? 8'h1F : (k < 10) ? 8'h0D : 8'hFF;
      n_tests++; if (wei !== ew || qc !== eq) begin n_fail++; $display("FAIL scan_%0d: got %b/%h expected %b/%h", k, wei, qc, ew, eq); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      stay = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 199) == 0) dir = ~dir;
      load = ($urandom_range(0, 59) == 0);
      load_val = ($urandom_range(0, 1) == 1) ? {8'h00, to_bcd(int'($urandom_range(0, 59)))} : 16'($urandom);
      step();
      n_tests++; if (dut.count !== to_bcd(m_val)) begin n_fail++; $display("FAIL rnd_count: got %h expected %h", dut.count, to_bcd(m_val)); end
      n_tests++; if (done !== m_done) begin n_fail++; $display("FAIL rnd_done: got %b expected %b", done, m_done); end
      n_tests++; if (qc !== m_qc) begin n_fail++; $display("FAIL rnd_qc: got %h expected %h", qc, m_qc); end
      n_tests++; if (wei !== m_wei) begin n_fail++; $display("FAIL rnd_wei: got %b expected %b", wei, m_wei); end
    end
    stay = 1'b0; load = 1'b0; dir = 1'b0;
  endtask

  task automatic test_async_clr();
    do_reset();
    dir = 1'b1;
    repeat (TICK_CYC) step();
    clr = 1'b1;
    #1;
    n_tests++; if (done !== 1'b0 || dut.count !== 8'h00) begin n_fail++; $display("FAIL aclr_count: got %b/%h expected 0/00", done, dut.count); end
    n_tests++; if (qc !== 8'hFF || wei !== 4'b1111) begin n_fail++; $display("FAIL aclr_disp1: got %h/%b expected ff/1111", qc, wei); end
    do_reset();
    load = 1'b1; load_val = 16'h0023;
    step();
    load = 1'b0;
    repeat (7) step();
    clr = 1'b1;
    #1;
    n_tests++; if (qc !== 8'hFF || wei !== 4'b1111 || dut.count !== 8'h00) begin n_fail++; $display("FAIL aclr_disp2: got %h/%b/%h expected ff/1111/00", qc, wei, dut.count); end
    do_reset();
  endtask

  task automatic test_lz();
    logic [3:0] ew;
    logic [7:0] eq;
    do_reset();
    load = 1'b1; load_val = 16'h0005;
    step();
    load = 1'b0;
    repeat (19) step();
    for (int k = 0; k < 20; k++) begin
      step();
      if (k < 5) begin ew = 4'b1110; eq = 8'h49; end
`ifdef LZ_BLANK_EN
      else begin ew = 4'b1111; eq = 8'hFF; end
`else
      else if (k < 10) begin ew = 4'b1101; eq = 8'h03; end
      else begin ew = 4'b1111; eq = 8'hFF; end
`endif
      n_tests++; if (wei !== ew || qc !== eq) begin n_fail++; $display("FAIL lz_%0d: got %b/%h expected %b/%h", k, wei, qc, ew, eq); end
    end
  endtask

  initial begin
    clr = 1'b1; stay = 1'b0; dir = 1'b0; load = 1'b0; load_val = 16'h0000;
    model_reset();
    test_reset();
    test_count_up();
    test_count_down();
    test_stay();
    test_load();
    test_scan();
    test_random();
    test_async_clr();
    test_lz();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
